// File: rtl/speaker_ctl.sv
// speaker_ctl: serializes latched 16-bit L/R PCM samples onto a DAC link (mclk, lrck, sck, sdin).
// Define SPK_I2S_DELAY_EN for Philips I2S (one-sck data delay); otherwise the output is left-justified.
module speaker_ctl #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] audio_in_left,
  input  logic [SAMPLE_W-1:0] audio_in_right,
  input  logic                mute,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin,
  output logic                sample_req
);

  logic [8:0]            cnt;
  logic [2*SAMPLE_W-1:0] shreg;
  logic [2*SAMPLE_W-1:0] frame_word;
  logic                  lj_bit;
  logic                  req_q;
  logic                  frame_end;
  logic                  slot_end;

  assign frame_end  = (cnt == 9'd511);
  assign slot_end   = (cnt[3:0] == 4'hF);
  assign frame_word = mute ? '0 : {audio_in_left, audio_in_right};

  // All DAC clocks are taps of one free-running counter, so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      req_q <= 1'b0;
    end else begin
      cnt   <= cnt + 9'd1;
      req_q <= frame_end;
    end
  end

  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[3];
  assign audio_lrck = cnt[8];
  assign sample_req = req_q;

  // The MSB goes straight to the output at the latch edge, so the register keeps only the remaining bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      lj_bit <= 1'b0;
    end else if (frame_end) begin
      lj_bit <= frame_word[2*SAMPLE_W-1];
      shreg  <= {frame_word[2*SAMPLE_W-2:0], 1'b0};
    end else if (slot_end) begin
      lj_bit <= shreg[2*SAMPLE_W-1];
      shreg  <= {shreg[2*SAMPLE_W-2:0], 1'b0};
    end
  end

`ifdef SPK_I2S_DELAY_EN
  logic i2s_bit;

  // I2S lags the left-justified stream by one slot; lj_bit doubles as the trailing-bit holder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2s_bit <= 1'b0;
    end else if (slot_end) begin
      i2s_bit <= lj_bit;
    end
  end

  assign audio_sdin = i2s_bit;
`else
  assign audio_sdin = lj_bit;
`endif

endmodule

// File: doc/speaker_ctl.md
# speaker_ctl

Audio output serializer that sits directly downstream of the tone/note generator in the audio path. It takes parallel 16-bit left/right PCM samples and drives the external DAC interface: master clock, left-right clock, serial clock and serial data. It is the block that produces `audio_mclk`, `audio_lrck`, `audio_sck` and `audio_sdin` at the top level. Samples are latched once per frame, and a one-cycle request pulse is returned to the sample source.

## Interface

- `SAMPLE_W`, default 16: bits per channel. It is fixed at 16 in this revision, and the frame structure below depends on it.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- `audio_in_left`  in  16  left sample, two's complement.
- `audio_in_right`  in  16  right sample, two's complement.
- `mute`  in  1  when high, zeros are latched instead of the inputs.
- `audio_mclk`  out  1  master clock, clk/4 (25 MHz).
- `audio_lrck`  out  1  left-right clock, clk/512 (195.3 kHz). Low means left, high means right.
- `audio_sck`  out  1  serial bit clock, clk/16 (6.25 MHz).
- `audio_sdin`  out  1  serial data, MSB first.
- `sample_req`  out  1  one-clk pulse; new samples may be presented.

## Operation

- A 9-bit free-running counter `cnt` increments every clk and wraps from 511 to 0. One frame is 512 clk long.
- Clock outputs:
  - `audio_mclk` = `cnt[1]`
  - `audio_sck` = `cnt[3]`
  - `audio_lrck` = `cnt[8]`
  - All three are register bits, so they are glitch-free.
- Each frame has 32 slots. The slot index is `k = cnt[8:4]`, and each slot is 16 clk long. Slots 0–15 are the left channel; slots 16–31 are the right channel.
- Latch:
  - On the clk edge that ends `cnt == 511`, the 32-bit shift register loads `{audio_in_left, audio_in_right}`, or 32'h0 if `mute` is high.
  - The inputs are sampled only at this edge. Changes at any other time are ignored until the next frame.
- Shift:
  - On each clk edge that ends a cycle with `cnt[3:0] == 15` (the `audio_sck` falling edge), `audio_sdin` takes the next bit.
  - In slot k, `audio_sdin` = frame bit `31-k`. Slot 0 carries `L[15]`; slot 31 carries `R[0]`.
  - Left-justified format: the MSB is coincident with the `audio_lrck` transition.
- `sample_req` is high for exactly the clk cycle in which `cnt == 0`, i.e. immediately after the latch edge.
  - The upstream block may update its samples at any point in the following 511 cycles.
  - Inputs must be stable at the edge ending `cnt == 511`.
- Arithmetic: the samples are passed through unmodified. There is no scaling, saturation or sign conversion.

## Timing

- Reset values: `cnt = 0`, shift register = 0, and `audio_mclk`, `audio_lrck`, `audio_sck`, `audio_sdin`, `sample_req` = 0. These take effect immediately on `rst_n` falling, independent of clk.
- First frame after reset:
  - The shift register holds 0, so `audio_sdin` is 0 for the whole of frame 0.
  - The first latch occurs at the edge ending `cnt == 511`.
  - The first `sample_req` occurs at clk 512 after release.
  - Latency from the input latch edge to the MSB on `audio_sdin` is 0 clk: the MSB is valid during `cnt` 0..15.
- `audio_sdin` changes only on `audio_sck` falling edges and is stable across every rising edge. The DAC samples on the rising edge, which is 8 clk after the data change.
- Reset mid-frame: the counter restarts at 0, the partial frame is discarded and no `sample_req` is issued. Behaviour is then identical to the first frame after reset.
- A `mute` change mid-frame takes effect at the next latch only.

## Configuration

- `SPK_I2S_DELAY_EN`
  - Defined: Philips I2S format. `audio_sdin` is delayed by one `audio_sck` period, so slot k carries frame bit `32-k`. Slot 0 carries the previous frame's `R[0]`, and `L[15]` appears in slot 1. An extra 1-bit register holds the trailing bit; its reset value is 0.
  - Undefined: left-justified format as described in Operation.
  - Clock outputs and `sample_req` timing are identical in both builds.

## Test plan

- Reset held for 4 clk, then released:
  - All outputs are 0 during reset.
  - After release, `audio_mclk` period = 4 clk, `audio_sck` period = 16 clk, `audio_lrck` period = 512 clk.
  - `sample_req` pulses at clk 512, 1024, …
- Inputs L = 16'hA5C3, R = 16'h0F0F held constant: sampling `audio_sdin` on 32 consecutive `audio_sck` rising edges of frame 1 yields 16'hA5C3 then 16'h0F0F, with `audio_lrck` low for the first 16 bits.
- L changes from 16'h1234 to 16'hFFFF at `cnt = 100`: the current frame still shifts 16'h1234, and the next frame shifts 16'hFFFF.
- `mute` = 1 with L = R = 16'h7FFF: the next frame's `audio_sdin` is all zeros, and `sample_req` continues every 512 clk.
- `rst_n` asserted at `cnt = 200`:
  - All outputs go to 0 before the next clk edge.
  - After release, `audio_lrck` stays low for 256 clk and `sample_req` first pulses 512 clk later.
- With `SPK_I2S_DELAY_EN` and L = 16'h8001, R = 16'h0001 repeated:
  - Slot 0 = 1 (previous `R[0]`).
  - Slot 1 = 1 (`L[15]`).
  - Slot 16 = 1 (`L[0]`).
  - Slot 17 = 0.
